// File: rtl/tt_pulse_pkg.sv
// Shared types and limits for the tt_pulse_gen edge-to-pulse generator.
package tt_pulse_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_t;

  localparam int MAX_CHANNELS = 8;

endpackage

// File: rtl/tt_pulse_chan.sv
// One edge-to-pulse channel: optional synchroniser, edge detect, down-counter, pulse flop.
// PULSE_GEN_SYNC_EN adds a SYNC_STAGES-deep input synchroniser; without it `in` must be clk-synchronous.
module tt_pulse_chan
  import tt_pulse_pkg::*;
#(
  parameter int WIDTH_BITS = 8
`ifdef PULSE_GEN_SYNC_EN
  ,
  parameter int SYNC_STAGES = 2
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  retrig,
  input  logic [WIDTH_BITS-1:0] len,
  input  logic                  in,
  output logic                  pulse
);

  logic                  s;
  logic                  prev;
  logic                  rise;
  logic                  fall;
  logic                  edge_hit;
  logic                  trig;
  logic [WIDTH_BITS-1:0] cnt;
  logic [WIDTH_BITS-1:0] len_m1;

`ifdef PULSE_GEN_SYNC_EN
  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], in};
  end

  assign s = sync[SYNC_STAGES-1];
`else
  assign s = in;
`endif

  // prev tracks the input even while disabled so re-enabling never fabricates an edge
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= s;
  end

  assign rise = s & ~prev;
  assign fall = ~s & prev;

  always_comb begin
    edge_hit = 1'b0;
    unique case (mode_t'(mode))
      MODE_OFF:  edge_hit = 1'b0;
      MODE_RISE: edge_hit = rise;
      MODE_FALL: edge_hit = fall;
      MODE_BOTH: edge_hit = rise | fall;
    endcase
  end

  assign trig   = en & edge_hit & (~pulse | retrig);
  assign len_m1 = (len == '0) ? '0 : len - WIDTH_BITS'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse <= 1'b0;
      cnt   <= '0;
    end else if (trig) begin
      pulse <= 1'b1;
      cnt   <= len_m1;
    end else if (pulse) begin
      if (cnt != '0) cnt <= cnt - WIDTH_BITS'(1);
      else           pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/tt_pulse_gen.sv
// Multi-channel edge-to-pulse generator top: CHANNELS independent tt_pulse_chan plus registered busy.
// Define PULSE_GEN_SYNC_EN to place a SYNC_STAGES-deep synchroniser in front of each channel.
module tt_pulse_gen
  import tt_pulse_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH_BITS  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  retrig,
  input  logic [WIDTH_BITS-1:0] len,
  input  logic [CHANNELS-1:0]   in,
  output logic [CHANNELS-1:0]   pulse_out,
  output logic                  busy
);

  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS || SYNC_STAGES < 2) begin : g_param_err
    $error("tt_pulse_gen: CHANNELS must be 1..8 and SYNC_STAGES >= 2");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    tt_pulse_chan #(
      .WIDTH_BITS (WIDTH_BITS)
`ifdef PULSE_GEN_SYNC_EN
      ,
      .SYNC_STAGES(SYNC_STAGES)
`endif
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .mode  (mode),
      .retrig(retrig),
      .len   (len),
      .in    (in[i]),
      .pulse (pulse_out[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= |pulse_out;
  end

endmodule

// File: tb/tb_tt_pulse_gen.sv
// Scoreboard bench for tt_pulse_gen: expected pulse_out/busy per cycle queued at stimulus time.
module tb_tt_pulse_gen;

`ifdef PULSE_GEN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       retrig;
  logic [7:0] len;
  logic [3:0] din;
  logic [3:0] pulse_out;
  logic       busy;

  typedef struct packed {
    logic [3:0] pulse;
    logic       busy;
  } exp_t;

  exp_t       q[$];
  logic [3:0] last_exp = 4'h0;
  int         n_checks = 0;
  int         n_errors = 0;

  tt_pulse_gen #(.CHANNELS(4), .WIDTH_BITS(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .retrig   (retrig),
    .len      (len),
    .in       (din),
    .pulse_out(pulse_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] p);
    exp_t e;
    e.pulse = p;
    e.busy  = |last_exp;
    q.push_back(e);
    last_exp = p;
  endtask

  task automatic push_n(input logic [3:0] p, input int n);
    for (int i = 0; i < n; i++) push(p);
  endtask

  // Reset clears busy as well, so it does not follow the one-cycle-lag rule.
  task automatic push_reset();
    exp_t e;
    e.pulse = 4'h0;
    e.busy  = 1'b0;
    q.push_back(e);
    last_exp = 4'h0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        check_eq("drain_timeout", 8'd1, 8'd0);
        q.delete();
        break;
      end
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check_eq("pulse_out", {4'h0, pulse_out}, {4'h0, e.pulse});
      check_eq("busy", {7'h0, busy}, {7'h0, e.busy});
    end
  end

  // Rising edges on in[2] two cycles apart; second lands after 2 pulse cycles for len=4.
  task automatic retrig_case(input logic [7:0] l, input logic r, input int high);
    len    = l;
    retrig = r;
    din[2] = 1'b1;
    push_n(4'h0, LAT);
    push_n(4'h4, high);
    push_n(4'h0, 4);
    @(negedge clk) din[2] = 1'b0;
    @(negedge clk) din[2] = 1'b1;
    @(negedge clk) din[2] = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b01; retrig = 1'b0; len = 8'd3; din = 4'h0;

    // 1: reset and clean release
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_pulse", {4'h0, pulse_out}, 8'h00);
    check_eq("reset_busy", {7'h0, busy}, 8'h00);
    rst = 1'b0;
    push_n(4'h0, 6);
    drain();

    // 2: RISE, len=3, then falling edge ignored
    din[0] = 1'b1;
    push_n(4'h0, LAT);
    push_n(4'h1, 3);
    push_n(4'h0, 3);
    drain();
    din[0] = 1'b0;
    push_n(4'h0, LAT + 5);
    drain();

    // 3: BOTH, len=0 -> one-cycle pulse per transition on in[1]
    mode = 2'b11;
    len  = 8'd0;
    for (int t = 0; t < 4; t++) begin
      din[1] = ~din[1];
      for (int k = 0; k < 4; k++) push((k == LAT) ? 4'h2 : 4'h0);
      repeat (4) @(negedge clk);
    end
    push_n(4'h0, 3);
    drain();

    // 4: retrigger mid-pulse and in the final cycle
    mode = 2'b01;
    retrig_case(8'd4, 1'b1, 6);
    retrig_case(8'd4, 1'b0, 4);
    retrig_case(8'd2, 1'b1, 4);
    retrig_case(8'd2, 1'b0, 2);
    retrig = 1'b0;

    // 5: en dropped mid-pulse, later edge while disabled ignored, re-enable clean
    len    = 8'd5;
    din[3] = 1'b1;
    push_n(4'h0, LAT);
    push_n(4'h8, 5);
    push_n(4'h0, 3);
    repeat (LAT + 1) @(negedge clk);
    en = 1'b0;
    drain();
    din[3] = 1'b0;
    @(negedge clk) din[3] = 1'b1;
    push_n(4'h0, LAT + 6);
    drain();
    en = 1'b1;
    push_n(4'h0, 6);
    drain();
    din[3] = 1'b0;
    push_n(4'h0, LAT + 3);
    drain();

    // mode OFF: no triggers on either edge
    mode   = 2'b00;
    din[1] = 1'b1;
    push_n(4'h0, LAT + 4);
    drain();
    din[1] = 1'b0;
    push_n(4'h0, LAT + 4);
    drain();

    // 6: reset at pulse cycle 2 of len=10; held-high input retriggers on release
    mode   = 2'b01;
    len    = 8'd10;
    din[0] = 1'b1;
    push_n(4'h0, LAT);
    push_n(4'h1, 2);
    drain();
    rst = 1'b1;
    push_reset();
    push_reset();
    drain();
    rst = 1'b0;
    push_n(4'h0, LAT);
    push_n(4'h1, 10);
    push_n(4'h0, 3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
